// File: rtl/nn_pkg.sv
// nn_pkg: Q5.10 fixed-point constants, activation encoding and saturation helper shared by nn layers
package nn_pkg;
  localparam int FRAC_BITS = 10;
  typedef logic signed [15:0] q_t;
  localparam q_t ONE = 16'sd1024;
  localparam q_t HALF = 16'sd512;
  localparam q_t Q_MAX = 16'sh7fff;
  localparam q_t Q_MIN = 16'sh8000;
  typedef enum logic [1:0] {
    ACT_ID   = 2'd0,
    ACT_RELU = 2'd1,
    ACT_HSIG = 2'd2,
    ACT_ID3  = 2'd3
  } act_e;
  function automatic q_t sat17(input logic signed [16:0] v);
    return (v[16] != v[15]) ? (v[16] ? Q_MIN : Q_MAX) : q_t'(v[15:0]);
  endfunction
endpackage

// File: rtl/nn_act_if.sv
// nn_act_if: input, output and bias-write signals of the nn_act activation stage
interface nn_act_if #(parameter int IDX_W = 4);
  logic idx_clr;
  logic in_valid;
  logic in_ready;
  logic signed [15:0] in_z;
  logic [1:0] act_sel;
  logic bias_we;
  logic [IDX_W-1:0] bias_addr;
  logic signed [15:0] bias_wdata;
  logic out_valid;
  logic out_ready;
  logic signed [15:0] out_y;
  logic [IDX_W-1:0] out_idx;
  modport master (
    output idx_clr, in_valid, in_z, act_sel, bias_we, bias_addr, bias_wdata, out_ready,
    input in_ready, out_valid, out_y, out_idx
  );
  modport slave (
    input idx_clr, in_valid, in_z, act_sel, bias_we, bias_addr, bias_wdata, out_ready,
    output in_ready, out_valid, out_y, out_idx
  );
endinterface

// File: rtl/nn_act_fn.sv
// nn_act_fn: combinational activation y = f(s, act_sel); hard sigmoid present only with NN_ACT_SIGMOID_EN
module nn_act_fn
  import nn_pkg::*;
(
  input  q_t   s,
  input  act_e act_sel,
  output q_t   y
);
  q_t relu;
  assign relu = s[15] ? '0 : s;
`ifdef NN_ACT_SIGMOID_EN
  q_t h;
  q_t hsig;
  assign h = (s >>> 2) + HALF;
  assign hsig = h[15] ? '0 : (h > ONE) ? ONE : h;
  assign y = (act_sel == ACT_HSIG) ? hsig : (act_sel == ACT_RELU) ? relu : s;
`else
  assign y = (act_sel == ACT_RELU || act_sel == ACT_HSIG) ? relu : s;
`endif
endmodule

// File: rtl/nn_act.sv
// nn_act: bias add, saturation and activation in a two-stage valid/ready pipeline (NN_ACT_SIGMOID_EN enables hard sigmoid)
module nn_act
  import nn_pkg::*;
#(
  parameter int N_NEURON = 16,
  parameter int IDX_W = 4
) (
  input logic clk,
  input logic rst_n,
  nn_act_if.slave bus
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_NEURON - 1);
  q_t bias [N_NEURON];
  q_t b;
  q_t s_sat;
  q_t s1;
  q_t y_fn;
  q_t y;
  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] idx1;
  logic [IDX_W-1:0] idx2;
  act_e act1;
  logic v1, v2, en1, en2, acc;
  assign en2 = !v2 || bus.out_ready;
  assign en1 = !v1 || en2;
  assign acc = bus.in_valid && en1;
  assign bus.in_ready = en1;
  assign bus.out_valid = v2;
  assign bus.out_y = y;
  assign bus.out_idx = idx2;
  assign b = bias[cnt];
  assign s_sat = sat17($signed({bus.in_z[15], bus.in_z}) + $signed({b[15], b}));
  nn_act_fn u_fn (.s(s1), .act_sel(act1), .y(y_fn));
  // bias register file, written independently of the data handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURON; i++) bias[i] <= '0;
    end else if (bus.bias_we && 32'(bus.bias_addr) < N_NEURON) begin
      bias[bus.bias_addr] <= bus.bias_wdata;
    end
  end
  // neuron index counter: clear wins over the increment of a simultaneous accept
  always_ff @(posedge clk) begin
    if (!rst_n || bus.idx_clr) begin
      cnt <= '0;
    end else if (acc) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end
  // pipeline registers: stage 1 holds the saturated sum, stage 2 the activated output
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      s1 <= '0;
      idx1 <= '0;
      act1 <= ACT_ID;
      y <= '0;
      idx2 <= '0;
    end else begin
      if (en1) v1 <= bus.in_valid;
      if (acc) begin
        s1 <= s_sat;
        idx1 <= cnt;
        act1 <= act_e'(bus.act_sel);
      end
      if (en2) v2 <= v1;
      if (en2 && v1) begin
        y <= y_fn;
        idx2 <= idx1;
      end
    end
  end
endmodule

// File: tb/tb_nn_act.sv
// tb_nn_act: directed scoreboard bench for nn_act with N_NEURON=3
module tb_nn_act;
  localparam int N = 3;
  localparam int IW = 2;
`ifdef NN_ACT_SIGMOID_EN
  localparam bit SIG = 1'b1;
`else
  localparam bit SIG = 1'b0;
`endif
  typedef struct {
    int y;
    int idx;
    int cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  nn_act_if #(.IDX_W(IW)) bus ();
  nn_act #(.N_NEURON(N), .IDX_W(IW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  exp_t q[$];
  int bias_m[N];
  int cnt_m = 0, cyc = 0, npass = 0, ntot = 0, last_lat = -1, last_idx = -1;
  int held_y = 0, held_idx = 0, sent = 0;
  bit acc, held_v = 1'b0;

  function automatic int model(int z, int b, int act);
    int s = z + b;
    s = (s > 32767) ? 32767 : (s < -32768) ? -32768 : s;
    if (act == 2 && SIG) begin
      int h = (s >>> 2) + 512;
      return (h < 0) ? 0 : (h > 1024) ? 1024 : h;
    end
    if (act == 1 || act == 2) return (s < 0) ? 0 : s;
    return s;
  endfunction

  task automatic check(string tag, logic signed [31:0] obs, logic signed [31:0] expv);
    ntot++;
    assert (obs === expv) npass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  task automatic tick();
    exp_t e;
    #1;
    acc = bus.in_valid && bus.in_ready;
    if (!rst_n) begin
      q.delete();
      cnt_m = 0;
      for (int i = 0; i < N; i++) bias_m[i] = 0;
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        check("hold_y", $signed(bus.out_y), held_y);
        check("hold_idx", bus.out_idx, held_idx);
      end
      held_v = bus.out_valid && !bus.out_ready;
      held_y = $signed(bus.out_y);
      held_idx = bus.out_idx;
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) check("spurious_out", 1, 0);
        else begin
          e = q.pop_front();
          check("out_y", $signed(bus.out_y), e.y);
          check("out_idx", bus.out_idx, e.idx);
          last_lat = cyc - e.cyc;
          last_idx = bus.out_idx;
        end
      end
      if (acc) q.push_back('{model($signed(bus.in_z), bias_m[cnt_m], bus.act_sel), cnt_m, cyc});
      cnt_m = bus.idx_clr ? 0 : acc ? ((cnt_m == N - 1) ? 0 : cnt_m + 1) : cnt_m;
      if (bus.bias_we && bus.bias_addr < N) bias_m[bus.bias_addr] = $signed(bus.bias_wdata);
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(int z, int act, bit clr);
    bus.in_valid = 1'b1;
    bus.in_z = 16'(z);
    bus.act_sel = 2'(act);
    bus.idx_clr = clr;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (acc) break;
    end
    if (!acc) check("send_timeout", 0, 1);
    bus.in_valid = 1'b0;
    bus.idx_clr = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0 && !bus.out_valid) break;
      tick();
    end
    check("drain", q.size(), 0);
  endtask

  task automatic wb(int a, int d);
    bus.bias_we = 1'b1;
    bus.bias_addr = IW'(a);
    bus.bias_wdata = 16'(d);
    tick();
    bus.bias_we = 1'b0;
  endtask

  initial begin
    bus.idx_clr = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_z = '0;
    bus.act_sel = '0;
    bus.bias_we = 1'b0;
    bus.bias_addr = '0;
    bus.bias_wdata = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_y", $signed(bus.out_y), 0);
    check("rst_out_idx", bus.out_idx, 0);
    check("rst_in_ready", bus.in_ready, 1);
    wb(0, 512);
    wb(1, 30000);
    wb(2, -30000);
    wb(3, 999);
    send(1024, 0, 1'b0);
    drain();
    check("latency", last_lat, 2);
    send(10000, 0, 1'b0);
    send(-10000, 1, 1'b0);
    drain();
    wb(0, 0);
    wb(1, 0);
    wb(2, 0);
    send(-4096, 2, 1'b0);
    send(0, 2, 1'b0);
    send(1024, 2, 1'b0);
    send(4096, 2, 1'b0);
    drain();
    send(5, 0, 1'b1);
    drain();
    check("clr_accept_idx", last_idx, 1);
    send(6, 0, 1'b0);
    drain();
    check("after_clr_idx", last_idx, 0);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.act_sel = 2'd0;
    sent = 0;
    for (int i = 0; i < 6; i++) begin
      bus.in_z = 16'(100 * (sent + 1));
      tick();
      if (acc) sent++;
    end
    #1;
    check("bp_accepts", sent, 2);
    check("bp_in_ready", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      bus.in_valid = (sent < 5);
      bus.in_z = 16'(100 * (sent + 1));
      if (sent == 5 && q.size() == 0 && !bus.out_valid) break;
      tick();
      if (acc) sent++;
    end
    bus.in_valid = 1'b0;
    check("bp_sent", sent, 5);
    check("bp_drain", q.size(), 0);
    wb(0, 777);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_z = 16'(50);
    tick();
    tick();
    check("full_before_rst", q.size(), 2);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_out_y", $signed(bus.out_y), 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    send(100, 0, 1'b0);
    drain();
    check("post_rst_idx", last_idx, 0);
    check("q_empty", q.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
